// File: rtl/matrix_input_loader.sv
// rtl/matrix_input_loader.sv - element stream to SRAM writes, three-beat command capture
//
// Purpose:
//   Front end of the matrix engine. The in_valid element stream carries
//   NUM_MAT square matrices of n = 2/4/8/16. Each element becomes one SRAM
//   write at {mat[4:0], row[3:0], col[3:0]}. Each matrix therefore sits on a
//   fixed 256-entry stride no matter what n is.
//   The in_valid2 stream carries one command as three beats: three matrix
//   indices, plus a mode on the first beat. The command is handed to the core
//   as one parallel word under a valid/ready handshake.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid           element beat valid
//   matrix             element value (row-major)
//   matrix_size        size code (00=2 .. 11=16), sampled on the first beat only
//   in_valid2          command beat valid
//   matrix_idx, mode   command beat payload (mode on the first beat only)
//   mem_we/addr/wdata  registered SRAM write port, one cycle behind the beat
//   cfg_size           size code of the current load
//   load_done          pulse on the cycle of the final write of a load
//   cmd_valid          command pending to the core
//   cmd_ready          core accepts the command
//   cmd_idx0..2        captured indices in beat order
//   cmd_mode           captured mode

module matrix_input_loader #(
    parameter int DATA_W  = 8,
    parameter int NUM_MAT = 32,
    parameter int ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] matrix,
    input  logic [1:0]        matrix_size,
    input  logic              in_valid2,
    input  logic [4:0]        matrix_idx,
    input  logic [1:0]        mode,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        cfg_size,
    output logic              load_done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [4:0]        cmd_idx0,
    output logic [4:0]        cmd_idx1,
    output logic [4:0]        cmd_idx2,
    output logic [1:0]        cmd_mode
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_CMD,
        CAPT,
        ISSUE
    } state_t;

    localparam logic [4:0] MAT_LAST = 5'(NUM_MAT - 1);

    state_t     state;
    state_t     state_next;

    logic [4:0] mat_cnt;
    logic [3:0] row_cnt;
    logic [3:0] col_cnt;
    // Tracks which of the two remaining command beats is expected next.
    // 0 means beat 2 is next, 1 means beat 3 is next.
    logic       beat_cnt;

    logic [3:0] dim_last;
    logic       load_start;
    logic       load_beat;
    logic       last_elem;
    logic       capt_start;
    logic       capt_beat;

    // n-1 for the latched size. Row and col wrap at this value, so the
    // unused high bits of row and col never leave zero.
    always_comb begin
        dim_last = 4'd1;
        case (cfg_size)
            2'b00:   dim_last = 4'd1;
            2'b01:   dim_last = 4'd3;
            2'b10:   dim_last = 4'd7;
            default: dim_last = 4'd15;
        endcase
    end

    always_comb begin
        load_start = in_valid && ((state == IDLE) || (state == WAIT_CMD));
        load_beat  = in_valid && (state == LOAD);
        last_elem  = load_beat && (mat_cnt == MAT_LAST)
                     && (row_cnt == dim_last) && (col_cnt == dim_last);
        // If element and command beats collide in WAIT_CMD, the load wins.
        capt_start = in_valid2 && !in_valid && (state == WAIT_CMD);
        capt_beat  = in_valid2 && (state == CAPT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (last_elem) begin
                    state_next = WAIT_CMD;
                end
            end
            WAIT_CMD: begin
                if (load_start) begin
                    state_next = LOAD;
                end else if (capt_start) begin
                    state_next = CAPT;
                end
            end
            CAPT: begin
                if (capt_beat && beat_cnt) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_next = WAIT_CMD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Element path. The first beat of a load is written at address 0, and the
    // counters are left pointing at element 1 for the next beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_done <= 1'b0;
            cfg_size  <= 2'b00;
            mat_cnt   <= 5'd0;
            row_cnt   <= 4'd0;
            col_cnt   <= 4'd0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            if (load_start) begin
                cfg_size  <= matrix_size;
                mem_we    <= 1'b1;
                mem_addr  <= '0;
                mem_wdata <= matrix;
                mat_cnt   <= 5'd0;
                row_cnt   <= 4'd0;
                col_cnt   <= 4'd1;
            end else if (load_beat) begin
                mem_we    <= 1'b1;
                mem_addr  <= ADDR_W'({mat_cnt, row_cnt, col_cnt});
                mem_wdata <= matrix;
                load_done <= last_elem;
                if (col_cnt == dim_last) begin
                    col_cnt <= 4'd0;
                    if (row_cnt == dim_last) begin
                        row_cnt <= 4'd0;
                        mat_cnt <= mat_cnt + 5'd1;
                    end else begin
                        row_cnt <= row_cnt + 4'd1;
                    end
                end else begin
                    col_cnt <= col_cnt + 4'd1;
                end
            end
        end
    end

    // Command path. The fields are only written in WAIT_CMD and CAPT, so they
    // cannot change while ISSUE presents them.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_idx0 <= 5'd0;
            cmd_idx1 <= 5'd0;
            cmd_idx2 <= 5'd0;
            cmd_mode <= 2'b00;
            beat_cnt <= 1'b0;
        end else begin
            if (capt_start) begin
                cmd_idx0 <= matrix_idx;
                cmd_mode <= mode;
                beat_cnt <= 1'b0;
            end else if (capt_beat) begin
                if (!beat_cnt) begin
                    cmd_idx1 <= matrix_idx;
                end else begin
                    cmd_idx2 <= matrix_idx;
                end
                beat_cnt <= ~beat_cnt;
            end
        end
    end

endmodule

// File: tb/tb_matrix_input_loader.sv
// tb/tb_matrix_input_loader.sv - randomized bench with behavioural model for matrix_input_loader

module tb_matrix_input_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] matrix = 8'd0;
    logic [1:0] matrix_size = 2'd0;
    logic       in_valid2 = 1'b0;
    logic [4:0] matrix_idx = 5'd0;
    logic [1:0] mode = 2'd0;
    logic       cmd_ready = 1'b0;

    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [1:0]  cfg_size;
    logic        load_done;
    logic        cmd_valid;
    logic [4:0]  cmd_idx0, cmd_idx1, cmd_idx2;
    logic [1:0]  cmd_mode;

    matrix_input_loader #(.DATA_W(8), .NUM_MAT(32), .ADDR_W(13)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .matrix(matrix),
        .matrix_size(matrix_size), .in_valid2(in_valid2), .matrix_idx(matrix_idx),
        .mode(mode), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cfg_size(cfg_size), .load_done(load_done), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_idx0(cmd_idx0), .cmd_idx1(cmd_idx1),
        .cmd_idx2(cmd_idx2), .cmd_mode(cmd_mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_WAIT = 2, P_CAPT = 3, P_ISSUE = 4;
    int          phase = P_IDLE;
    int          k = 0;
    int          nb = 0;
    logic        model_on = 1'b0;
    logic        e_rst = 1'b0, e_we = 1'b0, e_done = 1'b0;
    logic [12:0] e_addr = 13'd0;
    logic [7:0]  e_wdata = 8'd0;
    logic [1:0]  e_cfg = 2'd0, e_mode = 2'd0;
    logic [4:0]  e_i0 = 5'd0, e_i1 = 5'd0, e_i2 = 5'd0;

    // Element k of a load of size code sz, placed on a 256-entry stride per matrix.
    function automatic int addr_of(input int kk, input int sz);
        int n;
        int per;
        n = 2 << sz;
        per = n * n;
        return (kk / per) * 256 + ((kk % per) / n) * 16 + (kk % n);
    endfunction

    function automatic int total_of(input int sz);
        return 32 * (2 << sz) * (2 << sz);
    endfunction

    task automatic model_write();
        e_we = 1'b1;
        e_addr = 13'(addr_of(k, int'(e_cfg)));
        e_wdata = matrix;
        if (k == total_of(int'(e_cfg)) - 1) begin
            e_done = 1'b1;
            phase = P_WAIT;
        end
        k++;
    endtask

    always @(posedge clk) begin
        model_on = 1'b1;
        e_we = 1'b0;
        e_done = 1'b0;
        e_rst = 1'b0;
        if (rst) begin
            phase = P_IDLE; e_rst = 1'b1; k = 0;
            e_cfg = 2'd0; e_mode = 2'd0; e_i0 = 5'd0; e_i1 = 5'd0; e_i2 = 5'd0;
            e_addr = 13'd0; e_wdata = 8'd0;
        end else begin
            case (phase)
                P_IDLE, P_WAIT: begin
                    if (in_valid) begin
                        e_cfg = matrix_size; k = 0; phase = P_LOAD;
                        model_write();
                    end else if (phase == P_WAIT && in_valid2) begin
                        e_i0 = matrix_idx; e_mode = mode; nb = 1; phase = P_CAPT;
                    end
                end
                P_LOAD: if (in_valid) model_write();
                P_CAPT: begin
                    if (in_valid2) begin
                        if (nb == 1) e_i1 = matrix_idx;
                        else begin
                            e_i2 = matrix_idx;
                            phase = P_ISSUE;
                        end
                        nb++;
                    end
                end
                P_ISSUE: if (cmd_ready) phase = P_WAIT;
                default: phase = P_IDLE;
            endcase
        end
    end

    // ---------------- compare + observation process ----------------
    logic [12:0] addr_log [16384];
    int wr_cnt = 0, done_cnt = 0, done_at = -1;
    int cv_cur = 0, last_len = 0, hs_cnt = 0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("load_done", 32'(load_done), 32'(e_done));
            chk("cfg_size", 32'(cfg_size), 32'(e_cfg));
            chk("cmd_valid", 32'(cmd_valid), 32'(phase == P_ISSUE));
            if (e_we || e_rst) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            end
            if (phase == P_ISSUE || e_rst) begin
                chk("cmd_idx0", 32'(cmd_idx0), 32'(e_i0));
                chk("cmd_idx1", 32'(cmd_idx1), 32'(e_i1));
                chk("cmd_idx2", 32'(cmd_idx2), 32'(e_i2));
                chk("cmd_mode", 32'(cmd_mode), 32'(e_mode));
            end
            if (mem_we) begin
                addr_log[wr_cnt % 16384] = mem_addr;
                if (load_done) begin
                    done_cnt++;
                    done_at = wr_cnt;
                end
                wr_cnt++;
            end
            if (cmd_valid) begin
                cv_cur++;
                if (cmd_ready) begin
                    last_len = cv_cur;
                    cv_cur = 0;
                    hs_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rand();
        in_valid = 1'b0;
        in_valid2 = 1'($urandom % 2);
        matrix_idx = 5'($urandom);
        tick();
        in_valid2 = 1'b0;
    endtask

    task automatic load(input logic [1:0] sz, input int ga, input int gb,
                        input int stop, input bit seqval);
        int tot;
        tot = total_of(int'(sz));
        for (int kk = 0; kk < tot; kk++) begin
            if (kk == stop) break;
            if (kk == ga || kk == gb) begin
                repeat (3) idle_rand();
            end else if (kk > 0 && ($urandom % 16) == 0) begin
                repeat (1 + $urandom % 2) idle_rand();
            end
            in_valid = 1'b1;
            in_valid2 = 1'b0;
            matrix = seqval ? 8'(kk) : 8'($urandom);
            matrix_size = (kk == 0) ? sz : 2'($urandom);
            tick();
        end
        if (stop < 0) in_valid = 1'b0;
    endtask

    task automatic cgap();
        int n;
        n = $urandom % 3;
        for (int i = 0; i < n; i++) begin
            in_valid2 = 1'b0;
            in_valid = 1'($urandom % 2);
            tick();
        end
        in_valid = 1'b0;
    endtask

    logic [4:0] seen_i0, seen_i1, seen_i2;
    logic [1:0] seen_mode;

    task automatic command(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                           input logic [1:0] md, input int rdelay, input bit stray);
        cmd_ready = (rdelay == 0);
        in_valid = 1'b0;
        in_valid2 = 1'b1; matrix_idx = a; mode = md; tick();
        cgap();
        in_valid2 = 1'b1; matrix_idx = b; mode = 2'($urandom); tick();
        cgap();
        in_valid2 = 1'b1; matrix_idx = c; mode = 2'($urandom); tick();
        in_valid2 = 1'b0;
        chk("cmd_valid_rise", 32'(cmd_valid), 32'd1);
        seen_i0 = cmd_idx0; seen_i1 = cmd_idx1; seen_i2 = cmd_idx2; seen_mode = cmd_mode;
        for (int i = 0; i < rdelay; i++) begin
            if (stray && i == 1) begin
                in_valid2 = 1'b1; matrix_idx = ~c; mode = ~md;
            end
            tick();
            in_valid2 = 1'b0;
        end
        cmd_ready = 1'b1;
        tick();
        chk("cmd_valid_fall", 32'(cmd_valid), 32'd0);
        chk("cmd_len", 32'(last_len), 32'(rdelay + 1));
        cmd_ready = 1'($urandom % 2);
    endtask

    int base, d0, h0, bad;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cfg_size", 32'(cfg_size), 32'd0);

        // size 00, value = beat mod 256
        base = wr_cnt; d0 = done_cnt;
        load(2'b00, -1, -1, -1, 1'b1);
        repeat (2) tick();
        chk("t1_writes", 32'(wr_cnt - base), 32'd128);
        chk("t1_beat0_addr", 32'(addr_log[base]), 32'd0);
        chk("t1_beat4_addr", 32'(addr_log[base + 4]), 32'd256);
        chk("t1_beat127_addr", 32'(addr_log[base + 127]), 32'h1F11);
        chk("t1_done_at", 32'(done_at), 32'(base + 127));
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // command with ready already high
        command(5'd3, 5'd7, 5'd31, 2'd2, 0, 1'b0);
        chk("t3_idx0", 32'(seen_i0), 32'd3);
        chk("t3_idx1", 32'(seen_i1), 32'd7);
        chk("t3_idx2", 32'(seen_i2), 32'd31);
        chk("t3_mode", 32'(seen_mode), 32'd2);

        // same command with ready low for 5 cycles and a stray beat in ISSUE
        tick();
        command(5'd3, 5'd7, 5'd31, 2'd2, 5, 1'b1);
        chk("t4_idx2", 32'(seen_i2), 32'd31);
        chk("t4_mode", 32'(seen_mode), 32'd2);

        // size 11 with 3-cycle gaps at beats 100 and 5000
        tick();
        base = wr_cnt; d0 = done_cnt;
        load(2'b11, 100, 5000, -1, 1'b0);
        repeat (2) tick();
        chk("t2_writes", 32'(wr_cnt - base), 32'd8192);
        chk("t2_cfg_size", 32'(cfg_size), 32'd3);
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
        bad = 0;
        for (int i = 0; i < 8192; i++) if (addr_log[(base + i) % 16384] != 13'(i)) bad++;
        chk("t2_sequential", 32'(bad), 32'd0);

        // reset at size 10 beat 700
        d0 = done_cnt;
        load(2'b10, -1, -1, 700, 1'b0);
        rst = 1'b1; in_valid = 1'b1; matrix = 8'hA5;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        chk("t5_mem_addr", 32'(mem_addr), 32'd0);
        chk("t5_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("t5_cfg_size", 32'(cfg_size), 32'd0);
        chk("t5_cmd_idx0", 32'(cmd_idx0), 32'd0);
        chk("t5_cmd_mode", 32'(cmd_mode), 32'd0);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        base = wr_cnt;
        load(2'b01, -1, -1, -1, 1'b0);
        repeat (2) tick();
        chk("t5_first_addr", 32'(addr_log[base % 16384]), 32'd0);
        chk("t5_done_at", 32'(done_at), 32'(base + 511));
        chk("t5_writes", 32'(wr_cnt - base), 32'd512);

        // 10 commands with 1-3 idle cycles between
        h0 = hs_cnt;
        for (int c = 0; c < 10; c++) begin
            repeat (1 + $urandom % 3) tick();
            command(5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
                    int'($urandom % 3), 1'b0);
        end
        repeat (2) tick();
        chk("t6_handshakes", 32'(hs_cnt - h0), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_input_loader.md
# matrix_input_loader

Front-end stage of the lab5 matrix engine, directly downstream of the testbench stimulus interface and upstream of the compute core. It deserializes the `in_valid` element stream, which carries 32 square matrices of 2/4/8/16 dimension, into write transactions on the matrix SRAM. It also captures each three-beat `in_valid2` command, which carries three matrix indices and a mode, and issues it to the core as one parallel command with a valid/ready handshake.

## Interface

Parameters:

- `DATA_W`, default 8: element width.
- `NUM_MAT`, default 32: matrices per load.
- `ADDR_W`, default 13: SRAM address width, {mat[4:0], row[3:0], col[3:0]}.

Ports:

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  element beat valid.
- `matrix`  in  DATA_W  element value, row-major.
- `matrix_size`  in  2  00=2, 01=4, 10=8, 11=16; meaningful on the first beat of a load only.
- `in_valid2`  in  1  command beat valid.
- `matrix_idx`  in  5  matrix index; one per command beat.
- `mode`  in  2  operation mode; meaningful on the first command beat only.
- `mem_we`  out  1  SRAM write enable.
- `mem_addr`  out  ADDR_W  SRAM write address.
- `mem_wdata`  out  DATA_W  SRAM write data.
- `cfg_size`  out  2  size code latched for the current load.
- `load_done`  out  1  one-cycle pulse accompanying the final write.
- `cmd_valid`  out  1  command pending to core.
- `cmd_ready`  in  1  core accepts command.
- `cmd_idx0`, `cmd_idx1`, `cmd_idx2`  out  5 each  captured indices, in beat order.
- `cmd_mode`  out  2  captured mode.

## Operation

- States:
  - IDLE, LOAD, WAIT_CMD, CAPT, ISSUE.
  - Reset → IDLE.
- IDLE / WAIT_CMD, on `in_valid`=1:
  - Latch `matrix_size` into `cfg_size`.
  - Clear mat/row/col counters.
  - Process the beat as element 0.
  - Go to LOAD.
- LOAD, each beat with `in_valid`=1:
  - Write `matrix` to {mat,row,col}.
  - col increments; at n−1 col wraps to 0 and row increments.
  - At row n−1 / col n−1, row wraps and mat increments.
  - Unused high row/col bits stay 0, so each matrix occupies a fixed 256-entry stride.
  - `in_valid`=0 mid-load holds all counters (gap tolerated).
  - The write of element (31, n−1, n−1) asserts `load_done` → WAIT_CMD.
- Beats per load: 128 / 512 / 2048 / 8192 for n=2/4/8/16.
- WAIT_CMD, on `in_valid2`=1:
  - Store `matrix_idx` → idx0 and `mode` → cmd_mode.
  - Go to CAPT.
- CAPT:
  - Beat 2 → idx1; beat 3 → idx2, then go to ISSUE.
  - `in_valid2` low inside CAPT holds the beat counter.
- ISSUE:
  - `cmd_valid`=1; `cmd_idx*`/`cmd_mode` stable.
  - On a cycle with `cmd_ready`=1 → WAIT_CMD.
- Ignored inputs:
  - `in_valid2` in IDLE/LOAD/ISSUE.
  - `in_valid` in CAPT/ISSUE.
- A new load may start from WAIT_CMD; it fully overwrites `cfg_size`.

## Timing

- Reset values:
  - `mem_we`, `load_done`, `cmd_valid` = 0.
  - `mem_addr`, `mem_wdata`, `cfg_size`, `cmd_idx*`, `cmd_mode` = 0.
  - State IDLE; all counters 0.
- Write path, registered with latency 1: a beat sampled at edge t drives `mem_we`/`mem_addr`/`mem_wdata` during cycle t+1. `mem_we` is 0 on any cycle with no beat.
- `load_done`:
  - High exactly in the cycle of the last `mem_we`.
  - Never high otherwise.
- Command path:
  - Third `in_valid2` beat sampled at edge t → `cmd_valid`=1 from cycle t+1.
  - `cmd_valid`=1 is held until the edge where `cmd_ready`=1 is sampled; it is 0 the following cycle.
  - If `cmd_ready` is already 1, `cmd_valid` is high for exactly 1 cycle.
- Back-to-back: `in_valid2` may assert the cycle after handshake completion and is captured normally.
- `rst` mid-load or mid-command:
  - Next cycle all outputs take reset values.
  - Partial state is discarded; no pulse of `load_done` or `cmd_valid` occurs.

## Test plan

- Size 00, 128 beats with value = beat mod 256:
  - Beat 0 → addr 0.
  - Beat 4 → addr 256.
  - Beat 127 → addr 0x1F11, with `load_done` in that same cycle.
  - 128 writes total.
- Size 11, 8192 beats, with 3-cycle `in_valid` gaps at beats 100 and 5000:
  - Addresses strictly 0..8191, no skips.
  - `cfg_size`=3.
  - Exactly one `load_done`.
- Command beats idx=3,7,31 with mode=2 on beat 1, `cmd_ready`=1:
  - `cmd_valid` for 1 cycle, one cycle after beat 3.
  - idx0/1/2 = 3/7/31, mode 2.
- Same command with `cmd_ready` low for 5 cycles:
  - `cmd_valid` high for 6 cycles with stable fields.
  - A stray `in_valid2` beat during ISSUE does not alter the fields.
- `rst` asserted at size-10 beat 700:
  - Next cycle all outputs 0.
  - A new size-01 load afterwards starts at addr 0 and ends with `load_done` on beat 511.
- Size 01 load, then 10 commands separated by 1–3 idle cycles:
  - 10 `cmd_valid` handshakes.
  - Indices match stimulus order.
